// File: rtl/trap_unit_pkg.sv
// trap_unit_pkg: cause codes, mip bit indices, FSM states and vector/mcause helpers
package trap_unit_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ENTER, ST_RET} state_e;

    localparam int MEI_BIT = 11;
    localparam int MTI_BIT = 7;
    localparam int MSI_BIT = 3;

    localparam logic [3:0] IRQ_MEI = 4'd11;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MSI = 4'd3;

    localparam logic [1:0] MODE_VECTORED = 2'b01;

    function automatic logic [31:0] trap_vector(input logic [29:0] base, input logic [1:0] mode,
                                                input logic irq, input logic [3:0] code);
        return {base, 2'b00} + ((irq && mode == MODE_VECTORED) ? {26'd0, code, 2'b00} : 32'd0);
    endfunction

    function automatic logic [31:0] mcause_fmt(input logic irq, input logic [3:0] code);
        return {irq, 27'd0, code};
    endfunction

endpackage

// File: rtl/trap_unit_if.sv
// trap_unit_if: commit-point events in, fetch redirect and commit stall out
interface trap_unit_if;
    logic        pc_valid;
    logic [31:0] pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        mret;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;

    modport master (output pc_valid, pc, exc_valid, exc_cause, mret,
                    input  redirect, redirect_pc, stall);
    modport slave  (input  pc_valid, pc, exc_valid, exc_cause, mret,
                    output redirect, redirect_pc, stall);
endinterface

// File: rtl/trap_unit_irq_sync.sv
// irq_sync: STAGES-deep flop chain synchronizing one asynchronous level
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) chain_q <= '0;
        else       chain_q <= {chain_q[STAGES-2:0], d_i};
    end

    assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap sequencer owning mepc/mcause/MPIE and issuing fetch redirects
module trap_unit
    import trap_unit_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_soft_i,
    input  logic        mstatus_mie_i,
    input  logic        mie_meie_i,
    input  logic        mie_mtie_i,
    input  logic        mie_msie_i,
    input  logic [29:0] mtvec_base_i,
    input  logic [1:0]  mtvec_mode_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        mepc_we_i,
    input  logic        mcause_we_i,
    trap_unit_if.slave  cp,
    output logic [31:0] mip_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic        mpie_o,
    output logic        mie_clear_o,
    output logic        mie_restore_o
);
    state_e      state_q, state_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, target_q, target_d;
    logic        mpie_q, mpie_d;
    logic        ext_s, tim_s, soft_s;
    logic        pend_ext, pend_tim, pend_soft, int_take, trap_take, enter_now, ret_now, active;
    logic [3:0]  int_code, trap_code;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext  (.clk_i(clk_i), .rst_i(rst_i), .d_i(irq_ext_i),   .q_o(ext_s));
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tim  (.clk_i(clk_i), .rst_i(rst_i), .d_i(irq_timer_i), .q_o(tim_s));
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_soft (.clk_i(clk_i), .rst_i(rst_i), .d_i(irq_soft_i),  .q_o(soft_s));

    always_comb begin
        mip_o          = '0;
        mip_o[MEI_BIT] = ext_s;
        mip_o[MTI_BIT] = tim_s;
        mip_o[MSI_BIT] = soft_s;
    end

    assign pend_ext  = ext_s & mie_meie_i;
    assign pend_tim  = tim_s & mie_mtie_i;
    assign pend_soft = soft_s & mie_msie_i;
    assign int_take  = mstatus_mie_i & cp.pc_valid & (pend_ext | pend_tim | pend_soft);
    assign int_code  = pend_ext ? IRQ_MEI : pend_soft ? IRQ_MSI : IRQ_MTI;
    assign trap_take = cp.exc_valid | int_take;
    assign trap_code = cp.exc_valid ? cp.exc_cause : int_code;
    assign enter_now = (state_q == ST_IDLE) & trap_take;
    assign ret_now   = (state_q == ST_IDLE) & ~trap_take & cp.mret;

    // Trap capture beats a same-cycle software CSR write; MPIE is set on leaving RET
    // so the restore pulse still sees the pre-mret value.
    always_comb begin
        state_d  = (state_q != ST_IDLE) ? ST_IDLE : enter_now ? ST_ENTER : ret_now ? ST_RET : ST_IDLE;
        mepc_d   = enter_now ? cp.pc : mepc_we_i ? (csr_wdata_i & ~32'h3) : mepc_q;
        mcause_d = enter_now ? mcause_fmt(~cp.exc_valid, trap_code)
                 : mcause_we_i ? mcause_fmt(csr_wdata_i[31], csr_wdata_i[3:0]) : mcause_q;
        mpie_d   = enter_now ? mstatus_mie_i : (state_q == ST_RET) ? 1'b1 : mpie_q;
        target_d = enter_now ? trap_vector(mtvec_base_i, mtvec_mode_i, ~cp.exc_valid, trap_code)
                 : ret_now ? mepc_q : target_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mpie_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mpie_q   <= mpie_d;
            target_q <= target_d;
        end
    end

    // A reset arriving mid-sequence suppresses the pulse already in flight.
    assign active         = (state_q != ST_IDLE) & ~rst_i;
    assign cp.redirect    = active;
    assign cp.redirect_pc = target_q;
    assign cp.stall       = state_q != ST_IDLE;
    assign mie_clear_o    = active & (state_q == ST_ENTER);
    assign mie_restore_o  = active & (state_q == ST_RET);
    assign mepc_o         = mepc_q;
    assign mcause_o       = mcause_q;
    assign mpie_o         = mpie_q;
endmodule

// File: doc/trap_unit.md
# trap_unit

Machine-mode trap sequencer placed directly downstream of the CSR unit. It consumes the interrupt-enable and trap-vector state held there (mstatus.MIE, mie.MEIE/MTIE/MSIE, mtvec), synchronizes the raw interrupt lines and arbitrates between interrupts and synchronous exceptions. It owns mepc, mcause and mstatus.MPIE, and on trap entry or `mret` it issues a one-cycle PC redirect to fetch.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flop depth of each interrupt-line synchronizer; minimum 2.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `irq_ext_i`, `irq_timer_i`, `irq_soft_i`  in  1 each  asynchronous level interrupt lines.
- `mstatus_mie_i`  in  1  global interrupt enable, from the CSR unit.
- `mie_meie_i`, `mie_mtie_i`, `mie_msie_i`  in  1 each  per-source enables, from the CSR unit.
- `mtvec_base_i`  in  30  trap vector base [31:2].
- `mtvec_mode_i`  in  2  vector mode: 00 direct, 01 vectored, 1x treated as direct.
- `pc_valid_i`  in  1  a valid instruction occupies the commit point.
- `pc_i`  in  32  PC of that instruction.
- `exc_valid_i`  in  1  synchronous exception at the commit point.
- `exc_cause_i`  in  4  exception code.
- `mret_i`  in  1  `mret` at the commit point.
- `csr_wdata_i`  in  32  CSR write data.
- `mepc_we_i`, `mcause_we_i`  in  1 each  software CSR writes.
- `mip_o`  out  32  pending bits 11/7/3 (synchronized levels), all other bits 0.
- `mepc_o`, `mcause_o`  out  32 each  CSR readback.
- `mpie_o`  out  1  mstatus.MPIE readback.
- `mie_clear_o`  out  1  one-cycle pulse: CSR unit clears mstatus.MIE.
- `mie_restore_o`  out  1  one-cycle pulse: CSR unit loads MIE from `mpie_o`.
- `redirect_o`  out  1  one-cycle fetch redirect.
- `redirect_pc_o`  out  32  redirect target.
- `stall_o`  out  1  freeze commit; high while the state is not IDLE.

## Operation
- **Synchronizers:** each irq line passes through a `SYNC_STAGES` flop chain, reset value 0. `mip` is the synchronized level; it is not latched.
- **Interrupt qualifier:** `int_take = mstatus_mie_i & pc_valid_i & |(mip & mie)`.
- **Priority:** exception > MEI (cause 11) > MSI (3) > MTI (7).
- **mcause format:** bit31 = 1 for an interrupt, 0 for an exception; bits [3:0] hold the code; bits [30:4] are 0.
- **Vector:**
  - Vectored mode with an interrupt: `{base,2'b00} + (code<<2)`, 32-bit with wrap.
  - Otherwise: `{base,2'b00}`.
- **FSM states:** IDLE, ENTER, RET.
- **IDLE:**
  - `exc_valid_i` or `int_take` → ENTER. At the same edge, capture: mepc ← `pc_i`; mcause; MPIE ← `mstatus_mie_i`; vector target.
  - Else `mret_i` → RET, capturing target ← mepc.
- **ENTER:** `redirect_o`=1, `mie_clear_o`=1, `redirect_pc_o`=vector → IDLE.
- **RET:** `redirect_o`=1, `mie_restore_o`=1, `redirect_pc_o`=mepc, MPIE ← 1 → IDLE.
- **Inputs ignored outside IDLE:** `exc_valid_i`, `mret_i` and interrupts are ignored in ENTER/RET, because the pipeline is being flushed.
- **Software writes:**
  - `mepc_we_i` writes `csr_wdata_i & ~32'h3`.
  - `mcause_we_i` writes bit31 and bits [3:0].
  - A trap-entry capture in the same cycle wins over a software write.

## Timing
- **Reset values:**
  - Outputs: `redirect_o`, `stall_o`, `mie_clear_o`, `mie_restore_o` = 0; `redirect_pc_o` = 0; `mip_o`, `mepc_o`, `mcause_o` = 0.
  - State: `mpie_o` = 0; state = IDLE; synchronizer chains cleared.
- **Interrupt latency:** irq edge to `mip_o` visible is `SYNC_STAGES` cycles.
- **Trap entry:** decision in cycle N, then `redirect_o` and `stall_o` in N+1, then IDLE in N+2.
- **Back-to-back traps:** minimum 2 cycles apart.
- **Simultaneous events:**
  - `exc_valid_i` together with `mret_i` or with an interrupt: the exception wins.
  - `mret_i` with a pending interrupt: the interrupt wins, and mepc ← `pc_i` (the `mret` PC).
- **Interrupt deasserting after the decision:** the trap still completes with the latched cause.
- **`rst_i` in ENTER/RET:** next state is IDLE and no redirect pulse is emitted.
- **`pc_valid_i` = 0:** interrupts are deferred. Exceptions are taken regardless.

## Structure
- Exception and interrupt cause codes, the MEI/MTI/MSI bit indices and the FSM state encodings go in the shared `CSR_defs.vh`, beside the CSR addresses.
- Sub-module `irq_sync`: a parameterized `SYNC_STAGES` synchronizer with synchronous reset, instantiated three times.

## Test plan
- **Exception, direct mode:** `exc_valid_i`=1, cause 2, `pc_i`=0x100, mtvec=0x8000_0000 → N+1: `redirect_pc_o`=0x8000_0000, `mcause_o`=0x2, `mepc_o`=0x100, one `mie_clear_o` pulse.
- **Timer interrupt, vectored:** mtvec mode 01, base 0x200, MIE=1, MTIE=1, `irq_timer_i` raised → after 2+1 cycles `redirect_pc_o`=0x21C, `mcause_o`=0x8000_0007, `mpie_o`=1.
- **Priority:** ext, soft and timer lines plus `exc_valid_i` (cause 11) all asserted → exception taken, `mcause_o`=0xB. Next eligible cycle with the exception removed → `mcause_o`=0x8000_000B.
- **Masking:** interrupt pending with MIE=0 → no redirect for 20 cycles and `mip_o` bit 7 set. Set MIE=1 → trap is taken.
- **`mret`:** after a trap, `mret_i` → N+1: `redirect_pc_o`=mepc, one `mie_restore_o` pulse, `mpie_o`=1.
- **Reset and write collision:** `rst_i` pulsed during ENTER → no `redirect_o`, state IDLE. A `mepc_we_i` write of 0x1003 → `mepc_o`=0x1000. `mepc_we_i` in the same cycle as trap entry → mepc holds the trap PC.
